// File: rtl/ct_ifu_lbuf_pkg.sv
// Shared loop-buffer definitions used by the create (fill) side and the read side.
package ct_ifu_lbuf_pkg;

  localparam int ENTRY_NUM = 16;
  localparam int PTR_W     = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } lbuf_rd_state_e;

  typedef logic [15:0] lbuf_hw_t;

  // Entry pointer arithmetic wraps naturally because ENTRY_NUM is a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
    return p + {{(PTR_W-2){1'b0}}, n};
  endfunction

endpackage

// File: rtl/ct_ifu_lbuf_rd_ctrl_if.sv
// Bundle between the loop-buffer entry array / IB and the read controller.
interface ct_ifu_lbuf_rd_ctrl_if
  import ct_ifu_lbuf_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic                   lbuf_flush;
  logic                   fill_state_enter;
  logic                   active_state_enter;
  logic [PTR_W-1:0]       active_start_ptr;
  logic [ENTRY_NUM-1:0]   entry_vld_x;
  logic [ENTRY_NUM-1:0]   entry_32_start_x;
  logic [ENTRY_NUM-1:0]   entry_back_br_x;
  logic [ENTRY_NUM-1:0]   entry_fence_x;
  logic [16*ENTRY_NUM-1:0] entry_inst_data_v;
  logic                   ib_lbuf_rdy;

  logic                   lbuf_active;
  logic                   lbuf_inst0_vld;
  logic [31:0]            lbuf_inst0_data;
  logic                   lbuf_inst0_32;
  logic                   lbuf_inst1_vld;
  logic [31:0]            lbuf_inst1_data;
  logic                   lbuf_inst1_32;
  logic [PTR_W-1:0]       lbuf_rd_ptr;
  logic [CNT_W-1:0]       lbuf_loop_cnt;

  modport master (
    input  lbuf_flush, fill_state_enter, active_state_enter, active_start_ptr,
           entry_vld_x, entry_32_start_x, entry_back_br_x, entry_fence_x,
           entry_inst_data_v, ib_lbuf_rdy,
    output lbuf_active, lbuf_inst0_vld, lbuf_inst0_data, lbuf_inst0_32,
           lbuf_inst1_vld, lbuf_inst1_data, lbuf_inst1_32, lbuf_rd_ptr, lbuf_loop_cnt
  );

  modport slave (
    output lbuf_flush, fill_state_enter, active_state_enter, active_start_ptr,
           entry_vld_x, entry_32_start_x, entry_back_br_x, entry_fence_x,
           entry_inst_data_v, ib_lbuf_rdy,
    input  lbuf_active, lbuf_inst0_vld, lbuf_inst0_data, lbuf_inst0_32,
           lbuf_inst1_vld, lbuf_inst1_data, lbuf_inst1_32, lbuf_rd_ptr, lbuf_loop_cnt
  );

endinterface

// File: rtl/ct_ifu_lbuf_inst_extract.sv
// Reassembles one 16/32-bit instruction starting at a given half-word entry.
module ct_ifu_lbuf_inst_extract
  import ct_ifu_lbuf_pkg::*;
(
  input  logic [PTR_W-1:0]        ptr_i,
  input  logic [ENTRY_NUM-1:0]    entry_vld_i,
  input  logic [ENTRY_NUM-1:0]    entry_32_start_i,
  input  logic [ENTRY_NUM-1:0]    entry_back_br_i,
  input  logic [ENTRY_NUM-1:0]    entry_fence_i,
  input  logic [16*ENTRY_NUM-1:0] entry_inst_data_i,
  output logic                    vld_o,
  output logic [31:0]             data_o,
  output logic                    is32_o,
  output logic [1:0]              len_o,
  output logic                    back_br_o,
  output logic                    fence_o
);

  logic [PTR_W-1:0] ptr_hi;
  lbuf_hw_t         hw_lo;
  lbuf_hw_t         hw_hi;

  assign ptr_hi = ptr_add(ptr_i, 2'd1);
  assign hw_lo  = entry_inst_data_i[{ptr_i, 4'h0} +: 16];
  assign hw_hi  = entry_inst_data_i[{ptr_hi, 4'h0} +: 16];

  assign is32_o    = entry_32_start_i[ptr_i];
  assign len_o     = is32_o ? 2'd2 : 2'd1;
  // A 32-bit instruction is only usable once both halves have been written.
  assign vld_o     = entry_vld_i[ptr_i] & (~is32_o | entry_vld_i[ptr_hi]);
  assign data_o    = is32_o ? {hw_hi, hw_lo} : {16'h0000, hw_lo};
  assign back_br_o = entry_back_br_i[ptr_i];
  assign fence_o   = entry_fence_i[ptr_i];

endmodule

// File: rtl/ct_ifu_lbuf_rd_ctrl.sv
// Loop-buffer read side: walks the locked loop body and issues up to two instructions per cycle.
module ct_ifu_lbuf_rd_ctrl
  import ct_ifu_lbuf_pkg::*;
#(
  parameter int CNT_W = 8
)(
  input  logic                   lbuf_vld_update_clk,
  input  logic                   cpurst_b,
  ct_ifu_lbuf_rd_ctrl_if.master  lbuf_if
);

  lbuf_rd_state_e   state_q,      state_d;
  logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
  logic [PTR_W-1:0] loop_start_q, loop_start_d;
  logic [CNT_W-1:0] loop_cnt_q,   loop_cnt_d;

  logic             s0_vld, s0_is32, s0_bb, s0_fence;
  logic [31:0]      s0_data;
  logic [1:0]       s0_len;
  logic             s1_vld, s1_is32, s1_bb, s1_fence;
  logic [31:0]      s1_data;
  logic [1:0]       s1_len;
  logic [PTR_W-1:0] s1_ptr;

  logic             exit_req;
  logic             inst0_vld;
  logic             inst1_vld;
  logic             advance;
  logic             last_bb;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  ct_ifu_lbuf_inst_extract u_slot0 (
    .ptr_i             (rd_ptr_q),
    .entry_vld_i       (lbuf_if.entry_vld_x),
    .entry_32_start_i  (lbuf_if.entry_32_start_x),
    .entry_back_br_i   (lbuf_if.entry_back_br_x),
    .entry_fence_i     (lbuf_if.entry_fence_x),
    .entry_inst_data_i (lbuf_if.entry_inst_data_v),
    .vld_o             (s0_vld),
    .data_o            (s0_data),
    .is32_o            (s0_is32),
    .len_o             (s0_len),
    .back_br_o         (s0_bb),
    .fence_o           (s0_fence)
  );

  assign s1_ptr = ptr_add(rd_ptr_q, s0_len);

  ct_ifu_lbuf_inst_extract u_slot1 (
    .ptr_i             (s1_ptr),
    .entry_vld_i       (lbuf_if.entry_vld_x),
    .entry_32_start_i  (lbuf_if.entry_32_start_x),
    .entry_back_br_i   (lbuf_if.entry_back_br_x),
    .entry_fence_i     (lbuf_if.entry_fence_x),
    .entry_inst_data_i (lbuf_if.entry_inst_data_v),
    .vld_o             (s1_vld),
    .data_o            (s1_data),
    .is32_o            (s1_is32),
    .len_o             (s1_len),
    .back_br_o         (s1_bb),
    .fence_o           (s1_fence)
  );

  assign exit_req  = lbuf_if.lbuf_flush | lbuf_if.fill_state_enter;
  assign inst0_vld = (state_q == ACTIVE) & s0_vld & ~exit_req;
  // Fences issue alone and a back branch always ends the bundle.
  assign inst1_vld = inst0_vld & s1_vld & ~s0_bb & ~s0_fence & ~s1_fence;
  assign advance   = inst0_vld & lbuf_if.ib_lbuf_rdy;
  assign last_bb   = inst1_vld ? s1_bb : s0_bb;

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    loop_start_d = loop_start_q;
    loop_cnt_d   = loop_cnt_q;
    if (exit_req) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (lbuf_if.active_state_enter) begin
        state_d      = ACTIVE;
        rd_ptr_d     = lbuf_if.active_start_ptr;
        loop_start_d = lbuf_if.active_start_ptr;
        loop_cnt_d   = '0;
      end
    end else if (advance) begin
      if (last_bb) begin
        rd_ptr_d   = loop_start_q;
        loop_cnt_d = cnt_sat_inc(loop_cnt_q);
      end else begin
        rd_ptr_d   = ptr_add(s1_ptr, inst1_vld ? s1_len : 2'd0);
      end
    end
  end

  always_ff @(posedge lbuf_vld_update_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      loop_start_q <= '0;
      loop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      loop_start_q <= loop_start_d;
      loop_cnt_q   <= loop_cnt_d;
    end
  end

  assign lbuf_if.lbuf_active     = (state_q == ACTIVE);
  assign lbuf_if.lbuf_inst0_vld  = inst0_vld;
  assign lbuf_if.lbuf_inst0_data = inst0_vld ? s0_data : 32'h0;
  assign lbuf_if.lbuf_inst0_32   = inst0_vld & s0_is32;
  assign lbuf_if.lbuf_inst1_vld  = inst1_vld;
  assign lbuf_if.lbuf_inst1_data = inst1_vld ? s1_data : 32'h0;
  assign lbuf_if.lbuf_inst1_32   = inst1_vld & s1_is32;
  assign lbuf_if.lbuf_rd_ptr     = rd_ptr_q;
  assign lbuf_if.lbuf_loop_cnt   = loop_cnt_q;

endmodule

// File: tb/tb_ct_ifu_lbuf_rd_ctrl.sv
// Scoreboard bench for the loop-buffer read controller: a behavioural model predicts every cycle.
module tb_ct_ifu_lbuf_rd_ctrl;
  import ct_ifu_lbuf_pkg::*;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic cpurst_b = 1'b0;
  always #5 clk = ~clk;

  ct_ifu_lbuf_rd_ctrl_if #(.CNT_W(CNT_W)) lbuf_if();

  ct_ifu_lbuf_rd_ctrl #(.CNT_W(CNT_W)) u_dut (
    .lbuf_vld_update_clk (clk),
    .cpurst_b            (cpurst_b),
    .lbuf_if             (lbuf_if)
  );

  logic [15:0] t_vld, t_s32, t_bb, t_fn;
  logic [15:0] t_hw [16];
  logic        t_flush, t_fill, t_ase, t_rdy;
  logic [3:0]  t_asp;

  assign lbuf_if.lbuf_flush         = t_flush;
  assign lbuf_if.fill_state_enter   = t_fill;
  assign lbuf_if.active_state_enter = t_ase;
  assign lbuf_if.active_start_ptr   = t_asp;
  assign lbuf_if.entry_vld_x        = t_vld;
  assign lbuf_if.entry_32_start_x   = t_s32;
  assign lbuf_if.entry_back_br_x    = t_bb;
  assign lbuf_if.entry_fence_x      = t_fn;
  assign lbuf_if.ib_lbuf_rdy        = t_rdy;
  for (genvar g = 0; g < 16; g++) begin : g_hw
    assign lbuf_if.entry_inst_data_v[16*g +: 16] = t_hw[g];
  end

  typedef struct {
    logic        act;
    logic        v0;
    logic [31:0] d0;
    logic        s0;
    logic        v1;
    logic [31:0] d1;
    logic        s1;
    logic [3:0]  ptr;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;

  // Model state
  bit       m_act;
  int       m_ptr, m_start, m_cnt;
  bit       m_v0, m_v1;
  int       m_p1, m_l1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_rst();
    m_act = 0; m_ptr = 0; m_start = 0; m_cnt = 0; m_v0 = 0; m_v1 = 0; m_p1 = 0; m_l1 = 0;
  endtask

  task automatic model_eval();
    exp_t e;
    int p0, l0, p1, l1;
    bit ok0, ok1;
    if (!cpurst_b) model_rst();
    p0  = m_ptr;
    l0  = t_s32[p0] ? 2 : 1;
    ok0 = t_s32[p0] ? (t_vld[p0] && t_vld[(p0+1)%16]) : t_vld[p0];
    p1  = (p0 + l0) % 16;
    l1  = t_s32[p1] ? 2 : 1;
    ok1 = t_s32[p1] ? (t_vld[p1] && t_vld[(p1+1)%16]) : t_vld[p1];
    m_v0 = m_act && ok0 && !t_flush && !t_fill;
    m_v1 = m_v0 && ok1 && !t_bb[p0] && !t_fn[p0] && !t_fn[p1];
    m_p1 = p1;
    m_l1 = l1;
    e.act = m_act;
    e.v0  = m_v0;
    e.s0  = m_v0 && t_s32[p0];
    e.d0  = !m_v0 ? 32'h0 : (t_s32[p0] ? {t_hw[(p0+1)%16], t_hw[p0]} : {16'h0, t_hw[p0]});
    e.v1  = m_v1;
    e.s1  = m_v1 && t_s32[p1];
    e.d1  = !m_v1 ? 32'h0 : (t_s32[p1] ? {t_hw[(p1+1)%16], t_hw[p1]} : {16'h0, t_hw[p1]});
    e.ptr = 4'(m_ptr);
    e.cnt = 8'(m_cnt);
    sb_q.push_back(e);
  endtask

  task automatic model_seq();
    bit lb;
    if (!cpurst_b) begin
      model_rst();
    end else if (t_flush || t_fill) begin
      m_act = 0;
    end else if (!m_act) begin
      if (t_ase) begin
        m_act = 1; m_ptr = t_asp; m_start = t_asp; m_cnt = 0;
      end
    end else if (t_rdy && m_v0) begin
      lb = m_v1 ? t_bb[m_p1] : t_bb[m_ptr];
      if (lb) begin
        m_ptr = m_start;
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_ptr = (m_p1 + (m_v1 ? m_l1 : 0)) % 16;
      end
    end
  endtask

  task automatic cyc();
    exp_t e;
    #1;
    model_eval();
    e = sb_q.pop_front();
    check_val("active",  32'(lbuf_if.lbuf_active),     32'(e.act));
    check_val("i0_vld",  32'(lbuf_if.lbuf_inst0_vld),  32'(e.v0));
    check_val("i0_data", lbuf_if.lbuf_inst0_data,      e.d0);
    check_val("i0_32",   32'(lbuf_if.lbuf_inst0_32),   32'(e.s0));
    check_val("i1_vld",  32'(lbuf_if.lbuf_inst1_vld),  32'(e.v1));
    check_val("i1_data", lbuf_if.lbuf_inst1_data,      e.d1);
    check_val("i1_32",   32'(lbuf_if.lbuf_inst1_32),   32'(e.s1));
    check_val("rd_ptr",  32'(lbuf_if.lbuf_rd_ptr),     32'(e.ptr));
    check_val("loop_cnt",32'(lbuf_if.lbuf_loop_cnt),   32'(e.cnt));
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic clr_entries();
    t_vld = '0; t_s32 = '0; t_bb = '0; t_fn = '0;
    for (int i = 0; i < 16; i++) t_hw[i] = 16'(16'hA000 + i);
  endtask

  task automatic enter(input logic [3:0] sp);
    t_rdy = 1'b0; t_ase = 1'b1; t_asp = sp;
    cyc();
    t_ase = 1'b0;
  endtask

  task automatic leave();
    t_rdy = 1'b0; t_fill = 1'b1;
    cyc();
    t_fill = 1'b0;
    cyc();
  endtask

  initial begin
    t_flush = 0; t_fill = 0; t_ase = 0; t_rdy = 0; t_asp = '0;
    clr_entries();
    model_rst();

    // Reset state, with stimulus that would otherwise start reading
    t_vld = 16'hFFFF; t_ase = 1'b1; t_rdy = 1'b1;
    cyc(); cyc();
    cpurst_b = 1'b1;
    t_ase = 1'b0; t_rdy = 1'b0;
    clr_entries();
    cyc();

    // 16-bit loop 0..3, back branch at 3
    t_vld = 16'h000F; t_bb[3] = 1'b1;
    enter(4'd0);
    t_rdy = 1'b1;
    cyc(); cyc();
    check_val("loop16_ptr", 32'(lbuf_if.lbuf_rd_ptr), 32'd0);
    check_val("loop16_cnt", 32'(lbuf_if.lbuf_loop_cnt), 32'd1);
    cyc(); cyc();
    leave();

    // 32-bit instruction wrapping from entry 15 to entry 0
    clr_entries();
    t_s32[15] = 1'b1; t_vld[15] = 1'b1; t_vld[0] = 1'b1;
    enter(4'd15);
    #1;
    check_val("wrap_d0", lbuf_if.lbuf_inst0_data, 32'hA000_A00F);
    t_rdy = 1'b1;
    cyc();
    check_val("wrap_ptr", 32'(lbuf_if.lbuf_rd_ptr), 32'd1);
    cyc();
    leave();

    // Partially written 32-bit instruction stalls until its upper half arrives
    clr_entries();
    t_s32[4] = 1'b1; t_vld[4] = 1'b1;
    enter(4'd4);
    t_rdy = 1'b1;
    cyc(); cyc();
    check_val("part_hold", 32'(lbuf_if.lbuf_rd_ptr), 32'd4);
    t_vld[5] = 1'b1;
    cyc();
    check_val("part_adv", 32'(lbuf_if.lbuf_rd_ptr), 32'd6);
    leave();

    // Fence at entry 2 with the pointer at 1
    clr_entries();
    t_vld = 16'h001E; t_fn[2] = 1'b1;
    enter(4'd1);
    t_rdy = 1'b1;
    cyc(); cyc(); cyc();
    check_val("fence_ptr", 32'(lbuf_if.lbuf_rd_ptr), 32'd5);
    leave();

    // Flush arriving together with ready: no advance, then idle
    clr_entries();
    t_vld = 16'h000F; t_bb[3] = 1'b1;
    enter(4'd0);
    t_rdy = 1'b1;
    cyc();
    t_flush = 1'b1;
    cyc();
    t_flush = 1'b0;
    check_val("flush_ptr", 32'(lbuf_if.lbuf_rd_ptr), 32'd2);
    cyc();

    // Back-pressure then saturation of the iteration counter
    enter(4'd0);
    t_rdy = 1'b0;
    cyc(); cyc(); cyc();
    t_rdy = 1'b1;
    for (int i = 0; i < 600; i++) cyc();
    check_val("cnt_sat", 32'(lbuf_if.lbuf_loop_cnt), 32'd255);
    t_ase = 1'b1; t_asp = 4'd5;
    cyc();
    t_ase = 1'b0;

    // Reset in the middle of an active loop
    cpurst_b = 1'b0;
    cyc();
    cpurst_b = 1'b1;
    cyc();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      t_vld   = 16'($urandom) | 16'($urandom);
      t_s32   = 16'($urandom) & 16'($urandom);
      t_bb    = 16'($urandom) & 16'($urandom) & 16'($urandom);
      t_fn    = 16'($urandom) & 16'($urandom) & 16'($urandom);
      for (int k = 0; k < 16; k++) t_hw[k] = 16'($urandom);
      t_rdy   = ($urandom_range(0, 3) != 0);
      t_flush = ($urandom_range(0, 15) == 0);
      t_fill  = ($urandom_range(0, 15) == 0);
      t_ase   = ($urandom_range(0, 3) == 0);
      t_asp   = 4'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
